// File: rtl/flash_key_cmd_seq_if.sv
// Byte-level SPI master handshake between the key command sequencer and the SPI byte master.
// master: sequencer side (drives tx bytes, receives rx bytes); slave: SPI byte master side.
interface flash_key_cmd_seq_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/flash_key_cmd_seq.sv
// SPI-flash operation sequencer driven by debounced key pulses (read / page program / sector erase).
// Latches key requests, runs one op at a time (priority SE > WR > RD) and emits
// byte frames to an SPI byte master, one tx/rx handshake per byte.
// Optional build macro: POLL_TIMEOUT_EN -- bounds RDSR polling to POLL_MAX frames and raises err.
module flash_key_cmd_seq #(
  parameter int unsigned PAGE_BYTES = 16,
  parameter logic [7:0]  DATA_SEED  = 8'hA5,
  parameter int unsigned POLL_MAX   = 1000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        key_rd,
  input  logic                        key_wr,
  input  logic                        key_se,
  input  logic [23:0]                 flash_addr,
  flash_key_cmd_seq_if.master         spi,
  output logic [7:0]                  rd_data,
  output logic                        rd_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  if (PAGE_BYTES < 1 || PAGE_BYTES > 256) begin : g_bad_page_bytes
    $error("PAGE_BYTES must be in 1..256");
  end
  if (POLL_MAX < 1) begin : g_bad_poll_max
    $error("POLL_MAX must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN,
    S_CMD,
    S_WAIT_RX,
    S_POLL,
    S_POLL_CHK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_RD,
    OP_WR,
    OP_SE
  } op_t;

  // Index of the final byte of a RD/WR command frame (opcode + 3 address bytes + data).
  localparam logic [8:0] CMD_LAST_DATA = 9'(3 + PAGE_BYTES);

  // Pending request bits: [2]=SE, [1]=WR, [0]=RD.
  logic [2:0]  pend_q, pend_d, pend_clr;
  logic [2:0]  keys;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;       // frame state to resume after the rx byte returns
  op_t         op_q, op_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  cnt_q, cnt_d;       // byte index within the current frame
  logic        wip_q, wip_d;       // last RDSR status bit 0

  logic        tx_valid_d, tx_last_d;
  logic [7:0]  tx_data_d;
  logic [7:0]  rd_data_d;
  logic        rd_valid_d, busy_d, done_d, err_d;

  logic [7:0]  nxt_byte;
  logic        nxt_last;
  logic [8:0]  cmd_last;

`ifdef POLL_TIMEOUT_EN
  localparam int unsigned POLL_CNT_W = $clog2(POLL_MAX + 1);
  logic [POLL_CNT_W-1:0] poll_cnt_q, poll_cnt_d;
`endif

  assign keys = {key_se, key_wr, key_rd};

  // Next-state, next-output and pending-flag logic.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    op_d       = op_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    wip_d      = wip_q;
    tx_valid_d = spi.tx_valid;
    tx_data_d  = spi.tx_data;
    tx_last_d  = spi.tx_last;
    rd_data_d  = rd_data;
    rd_valid_d = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = err;
    pend_clr   = '0;
`ifdef POLL_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif

    cmd_last = (op_q == OP_SE) ? 9'd3 : CMD_LAST_DATA;

    // Byte the current frame state would present next.
    nxt_byte = '0;
    nxt_last = 1'b0;
    case (state_q)
      S_WREN: begin
        nxt_byte = 8'h06;
        nxt_last = 1'b1;
      end
      S_POLL: begin
        nxt_byte = (cnt_q == 9'd0) ? 8'h05 : 8'h00;
        nxt_last = (cnt_q != 9'd0);
      end
      S_CMD: begin
        case (cnt_q)
          9'd0: begin
            case (op_q)
              OP_SE:   nxt_byte = 8'hD8;
              OP_WR:   nxt_byte = 8'h02;
              default: nxt_byte = 8'h03;
            endcase
          end
          9'd1:    nxt_byte = addr_q[23:16];
          9'd2:    nxt_byte = addr_q[15:8];
          9'd3:    nxt_byte = addr_q[7:0];
          default: nxt_byte = (op_q == OP_WR) ? DATA_SEED + (cnt_q[7:0] - 8'd4) : 8'h00;
        endcase
        nxt_last = (cnt_q == cmd_last);
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          addr_d = flash_addr;
          cnt_d  = '0;
          busy_d = 1'b1;
          err_d  = 1'b0;
`ifdef POLL_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
          if (pend_q[2]) begin
            op_d        = OP_SE;
            pend_clr[2] = 1'b1;
            state_d     = S_WREN;
          end else if (pend_q[1]) begin
            op_d        = OP_WR;
            pend_clr[1] = 1'b1;
            state_d     = S_WREN;
          end else begin
            op_d        = OP_RD;
            pend_clr[0] = 1'b1;
            state_d     = S_CMD;
          end
        end
      end

      S_WREN, S_CMD, S_POLL: begin
        if (!spi.tx_valid) begin
          tx_valid_d = 1'b1;
          tx_data_d  = nxt_byte;
          tx_last_d  = nxt_last;
        end else if (spi.tx_ready) begin
          tx_valid_d = 1'b0;
          ret_d      = state_q;
          state_d    = S_WAIT_RX;
        end
      end

      // tx_last still holds the flag of the byte just accepted, so it marks frame end here.
      S_WAIT_RX: begin
        if (spi.rx_valid) begin
          if (ret_q == S_CMD && op_q == OP_RD && cnt_q >= 9'd4) begin
            rd_data_d  = spi.rx_data;
            rd_valid_d = 1'b1;
          end
          if (spi.tx_last) begin
            cnt_d = '0;
            case (ret_q)
              S_WREN:  state_d = S_CMD;
              S_CMD:   state_d = (op_q == OP_RD) ? S_DONE : S_POLL;
              default: begin
                wip_d   = spi.rx_data[0];
                state_d = S_POLL_CHK;
`ifdef POLL_TIMEOUT_EN
                poll_cnt_d = poll_cnt_q + POLL_CNT_W'(1);
`endif
              end
            endcase
          end else begin
            cnt_d   = cnt_q + 9'd1;
            state_d = ret_q;
          end
        end
      end

      S_POLL_CHK: begin
        if (!wip_q) begin
          state_d = S_DONE;
        end else begin
`ifdef POLL_TIMEOUT_EN
          if (poll_cnt_q == POLL_CNT_W'(POLL_MAX)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_POLL;
          end
`else
          state_d = S_POLL;
`endif
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A key for an op already pending is dropped; clearing wins over a same-cycle key.
    pend_d = (pend_q & ~pend_clr) | (keys & ~pend_q);
  end

  // State and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      op_q         <= OP_RD;
      addr_q       <= '0;
      cnt_q        <= '0;
      wip_q        <= 1'b0;
      pend_q       <= '0;
      spi.tx_valid <= 1'b0;
      spi.tx_data  <= '0;
      spi.tx_last  <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
`ifdef POLL_TIMEOUT_EN
      poll_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      wip_q        <= wip_d;
      pend_q       <= pend_d;
      spi.tx_valid <= tx_valid_d;
      spi.tx_data  <= tx_data_d;
      spi.tx_last  <= tx_last_d;
      rd_data      <= rd_data_d;
      rd_valid     <= rd_valid_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
`ifdef POLL_TIMEOUT_EN
      poll_cnt_q   <= poll_cnt_d;
`endif
    end
  end

endmodule
